cpu_controller: RTL and testbench



---
 rtl/cpu_pkg.sv | 28 ++
 rtl/cpu_controller.sv | 117 +++++++++++
 tb/tb_cpu_controller.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the accumulator CPU: opcode encoding and the
// sequencer state enumeration.
package cpu_pkg;

    typedef enum logic [2:0] {
        HLT = 3'b000,
        SKZ = 3'b001,
        ADD = 3'b010,
        AND = 3'b011,
        XOR = 3'b100,
        LDA = 3'b101,
        STO = 3'b110,
        JMP = 3'b111
    } opcode_e;

    typedef enum logic [3:0] {
        IDLE,
        F0,
        F1,
        DEC,
        E0,
        E1,
        E2,
        E3,
        HALT
    } state_e;

endpackage

// File: rtl/cpu_controller.sv
// Fixed-length fetch/decode/execute sequencer for the 8-bit accumulator CPU.
// Every output is decoded from registered state only (state, op_q, zq).
module cpu_controller
    import cpu_pkg::*;
#(
    parameter int RET_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ena,
    input  logic [2:0]       opcode,
    input  logic             zero,
    output logic             inc_pc,
    output logic             load_pc,
    output logic             rd,
    output logic             wr,
    output logic             load_ir,
    output logic             load_acc,
    output logic             con_alu,
    output logic             datactl_ena,
    output logic             halt,
    output logic [RET_W-1:0] ret_cnt,
    output state_e           dbg_state
);

    // Handshake: none. ena is a level sampled only in IDLE and E3; strobes are
    // single-cycle levels valid for the whole cycle of the state that owns them.
    state_e     state, state_nxt;
    opcode_e    op_q;
    logic       zq;
    logic       alu_op;

    assign dbg_state = state;
    assign alu_op    = (op_q == ADD) || (op_q == AND) || (op_q == XOR) || (op_q == LDA);

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            op_q    <= HLT;
            zq      <= 1'b1;
            ret_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (state == DEC) begin
                op_q <= opcode_e'(opcode);
                zq   <= zero;
            end
            if (state == E3) begin
                ret_cnt <= ret_cnt + RET_W'(1);
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = ena ? F0 : IDLE;
            F0:      state_nxt = F1;
            F1:      state_nxt = DEC;
            DEC:     state_nxt = E0;
            E0:      state_nxt = (op_q == HLT) ? HALT : E1;
            E1:      state_nxt = E2;
            E2:      state_nxt = E3;
            E3:      state_nxt = ena ? F0 : IDLE;
            HALT:    state_nxt = HALT;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        inc_pc      = 1'b0;
        load_pc     = 1'b0;
        rd          = 1'b0;
        wr          = 1'b0;
        load_ir     = 1'b0;
        load_acc    = 1'b0;
        con_alu     = 1'b0;
        datactl_ena = 1'b0;
        halt        = 1'b0;
        case (state)
            F0, F1: begin
                rd      = 1'b1;
                load_ir = 1'b1;
                inc_pc  = 1'b1;
            end
            E0: begin
                halt    = (op_q == HLT);
                rd      = alu_op;
                con_alu = (op_q == STO);
                load_pc = (op_q == JMP);
            end
            E1: begin
                rd          = alu_op;
                con_alu     = alu_op;
                datactl_ena = (op_q == STO);
                inc_pc      = (op_q == SKZ) && zq;
            end
            // load_acc here captures the ALU result registered at the end of E1.
            E2: begin
                rd          = alu_op;
                load_acc    = alu_op;
                datactl_ena = (op_q == STO);
                wr          = (op_q == STO);
                inc_pc      = (op_q == SKZ) && zq;
            end
            E3: begin
                datactl_ena = (op_q == STO);
            end
            HALT: begin
                halt = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_cpu_controller.sv
// Bench for cpu_controller: instruction-level model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_cpu_controller;
    import cpu_pkg::*;

    logic        clk, rst, ena, zero;
    logic [2:0]  opcode;

    logic        inc_pc, load_pc, rd, wr, load_ir, load_acc, con_alu, datactl_ena, halt;
    logic [15:0] ret_cnt;
    state_e      dbg_state;

    logic        inc_pc_b, load_pc_b, rd_b, wr_b, load_ir_b, load_acc_b, con_alu_b, datactl_ena_b, halt_b;
    logic [3:0]  ret_cnt_b;
    state_e      dbg_state_b;

    int checks = 0;
    int errors = 0;
    logic chk_en = 1'b0;

    cpu_controller #(.RET_W(16)) dut (
        .clk(clk), .rst(rst), .ena(ena), .opcode(opcode), .zero(zero),
        .inc_pc(inc_pc), .load_pc(load_pc), .rd(rd), .wr(wr), .load_ir(load_ir),
        .load_acc(load_acc), .con_alu(con_alu), .datactl_ena(datactl_ena),
        .halt(halt), .ret_cnt(ret_cnt), .dbg_state(dbg_state)
    );

    cpu_controller #(.RET_W(4)) dut_b (
        .clk(clk), .rst(rst), .ena(ena), .opcode(opcode), .zero(zero),
        .inc_pc(inc_pc_b), .load_pc(load_pc_b), .rd(rd_b), .wr(wr_b), .load_ir(load_ir_b),
        .load_acc(load_acc_b), .con_alu(con_alu_b), .datactl_ena(datactl_ena_b),
        .halt(halt_b), .ret_cnt(ret_cnt_b), .dbg_state(dbg_state_b)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Instruction-level model: mode 0=idle 1=running 2=halted, phase 0..6 = F0..E3.
    int m_mode = 0, m_phase = 0, m_op = 0, m_ret = 0;
    logic m_zq = 1'b1;

    always @(posedge clk) begin
        if (rst) begin
            m_mode = 0; m_phase = 0; m_op = 0; m_zq = 1'b1; m_ret = 0;
        end else if (m_mode == 0) begin
            if (ena) begin m_mode = 1; m_phase = 0; end
        end else if (m_mode == 1) begin
            if (m_phase == 2) begin m_op = int'(opcode); m_zq = zero; end
            if (m_phase == 3 && m_op == 0) m_mode = 2;
            else if (m_phase == 6) begin
                m_ret = (m_ret + 1) % 65536;
                if (ena) m_phase = 0; else m_mode = 0;
            end else m_phase++;
        end
    end

    // {halt, inc_pc, load_pc, rd, wr, load_ir, load_acc, con_alu, datactl_ena}
    function automatic logic [8:0] exp_strobes();
        logic run, fetch, aluop, sto;
        int e;
        run   = (m_mode == 1);
        fetch = run && m_phase < 2;
        e     = run ? m_phase - 3 : -9;
        aluop = (m_op >= 2 && m_op <= 5);
        sto   = (m_op == 6);
        return {
            m_mode == 2 || (e == 0 && m_op == 0),
            fetch || (m_op == 1 && m_zq && (e == 1 || e == 2)),
            e == 0 && m_op == 7,
            fetch || (aluop && e >= 0 && e <= 2),
            sto && e == 2,
            fetch,
            aluop && e == 2,
            (aluop && e == 1) || (sto && e == 0),
            sto && e >= 1 && e <= 3
        };
    endfunction

    function automatic state_e exp_state();
        state_e run_st[7] = '{F0, F1, DEC, E0, E1, E2, E3};
        if (m_mode == 0) return IDLE;
        if (m_mode == 2) return HALT;
        return run_st[m_phase];
    endfunction

    // scoreboard: compare both instances against the model every cycle
    always @(negedge clk) begin
        if (chk_en) begin
            check("strobes", {23'd0, halt, inc_pc, load_pc, rd, wr, load_ir, load_acc, con_alu, datactl_ena},
                  {23'd0, exp_strobes()});
            check("strobes_w4", {23'd0, halt_b, inc_pc_b, load_pc_b, rd_b, wr_b, load_ir_b, load_acc_b, con_alu_b,
                  datactl_ena_b}, {23'd0, exp_strobes()});
            check("state", 32'(dbg_state), 32'(exp_state()));
            check("ret_cnt", 32'(ret_cnt), 32'(m_ret));
            check("ret_cnt_w4", 32'(ret_cnt_b), 32'(m_ret % 16));
            check("wr_without_dctl", 32'(wr && !datactl_ena), 32'd0);
            check("rd_and_wr", 32'(rd && wr), 32'd0);
        end
    end

    // driver tasks
    task automatic step();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1; ena = 1'b0;
        step();
        rst = 1'b0;
    endtask

    logic [6:0] p_rd, p_ir, p_inc, p_alu, p_acc, p_dctl, p_wr, p_ldpc;
    state_e     first_st;

    // Runs one instruction from IDLE; pattern bit i is the strobe in cycle i (F0=0 .. E3=6).
    task automatic run_one(input logic [2:0] op, input logic z_dec, input logic z_late,
                           input int drop_at, input int rst_at);
        opcode = op; zero = z_dec; ena = 1'b1;
        step();
        first_st = dbg_state;
        {p_rd, p_ir, p_inc, p_alu, p_acc, p_dctl, p_wr, p_ldpc} = '0;
        for (int i = 0; i < 7; i++) begin
            p_rd[i] = rd; p_ir[i] = load_ir; p_inc[i] = inc_pc; p_alu[i] = con_alu;
            p_acc[i] = load_acc; p_dctl[i] = datactl_ena; p_wr[i] = wr; p_ldpc[i] = load_pc;
            if (i == rst_at) begin
                rst = 1'b1; ena = 1'b0;
                step();
                rst = 1'b0;
                return;
            end
            if (i == 3) zero = z_late;
            if (i == drop_at || i == 6) ena = 1'b0;
            step();
        end
    endtask

    initial begin
        int hcnt, rdcnt, idle_cnt;
        logic [15:0] ret_before;
        logic [3:0]  r15;
        rst = 1'b1; ena = 1'b0; opcode = 3'd0; zero = 1'b0;
        step();
        do_reset();
        chk_en = 1'b1;
        check("reset_state", 32'(dbg_state), 32'(IDLE));
        check("reset_halt", 32'(halt), 32'd0);
        check("reset_ret", 32'(ret_cnt), 32'd0);

        // LDA
        run_one(3'(LDA), 1'b0, 1'b0, -1, -1);
        check("lda_first_f0", 32'(first_st), 32'(F0));
        check("lda_rd", 32'(p_rd), 32'b0111011);
        check("lda_load_ir", 32'(p_ir), 32'b0000011);
        check("lda_inc_pc", 32'(p_inc), 32'b0000011);
        check("lda_con_alu", 32'(p_alu), 32'b0010000);
        check("lda_load_acc", 32'(p_acc), 32'b0100000);
        check("lda_ret", 32'(ret_cnt), 32'd1);
        check("lda_idle", 32'(dbg_state), 32'(IDLE));

        // SKZ: taken, taken with late zero change, not taken
        run_one(3'(SKZ), 1'b1, 1'b1, -1, -1);
        check("skz_z1_inc", 32'(p_inc), 32'b0110011);
        run_one(3'(SKZ), 1'b1, 1'b0, -1, -1);
        check("skz_late0_inc", 32'(p_inc), 32'b0110011);
        run_one(3'(SKZ), 1'b0, 1'b1, -1, -1);
        check("skz_z0_inc", 32'(p_inc), 32'b0000011);

        // STO
        run_one(3'(STO), 1'b0, 1'b0, -1, -1);
        check("sto_con_alu", 32'(p_alu), 32'b0001000);
        check("sto_dctl", 32'(p_dctl), 32'b1110000);
        check("sto_wr", 32'(p_wr), 32'b0100000);
        check("sto_rd", 32'(p_rd), 32'b0000011);

        // JMP with ena dropped in E1
        run_one(3'(JMP), 1'b0, 1'b0, 4, -1);
        check("jmp_load_pc", 32'(p_ldpc), 32'b0001000);
        check("jmp_idle", 32'(dbg_state), 32'(IDLE));
        check("jmp_ret", 32'(ret_cnt), 32'd6);
        rdcnt = 0;
        for (int i = 0; i < 5; i++) begin
            rdcnt += int'(rd);
            step();
        end
        check("jmp_no_more_rd", 32'(rdcnt), 32'd0);

        // HLT: sticky while ena toggles
        ret_before = ret_cnt;
        opcode = 3'(HLT); ena = 1'b1;
        for (int i = 0; i < 4; i++) step();
        check("hlt_e0_halt", 32'(halt), 32'd1);
        hcnt = 0;
        for (int i = 0; i < 22; i++) begin
            ena = 1'($urandom_range(0, 1));
            step();
            hcnt += int'(halt);
        end
        check("hlt_sticky", 32'(hcnt), 32'd22);
        check("hlt_ret_frozen", 32'(ret_cnt), 32'(ret_before));
        check("hlt_state", 32'(dbg_state), 32'(HALT));
        do_reset();
        check("hlt_rst_halt", 32'(halt), 32'd0);
        check("hlt_rst_state", 32'(dbg_state), 32'(IDLE));

        // Reset during E1 of an ADD suppresses load_acc
        run_one(3'(ADD), 1'b0, 1'b0, -1, 4);
        check("midrst_state", 32'(dbg_state), 32'(IDLE));
        check("midrst_ret", 32'(ret_cnt), 32'd0);
        check("midrst_no_acc", 32'(p_acc), 32'd0);
        for (int i = 0; i < 3; i++) begin
            check("midrst_acc_after", 32'(load_acc), 32'd0);
            step();
        end

        // 16 back-to-back ADDs, 4-bit counter wraps
        do_reset();
        opcode = 3'(ADD); ena = 1'b1;
        step();
        idle_cnt = 0; r15 = '0;
        for (int k = 0; k < 16 * 7; k++) begin
            if (dbg_state == IDLE) idle_cnt++;
            if (k == 15 * 7) r15 = ret_cnt_b;
            if (k == 16 * 7 - 1) ena = 1'b0;
            step();
        end
        check("b2b_no_idle", 32'(idle_cnt), 32'd0);
        check("b2b_ret15", 32'(r15), 32'd15);
        check("b2b_wrap", 32'(ret_cnt_b), 32'd0);
        check("b2b_ret16", 32'(ret_cnt), 32'd16);

        // randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            rst    = ($urandom_range(0, 59) == 0);
            ena    = ($urandom_range(0, 3) != 0);
            opcode = ($urandom_range(0, 24) == 0) ? 3'd0 : 3'($urandom_range(1, 7));
            zero   = 1'($urandom_range(0, 1));
            step();
        end
        rst = 1'b0; ena = 1'b0;
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
